rom_fetch_responder: RTL
========================

// Module: rom_fetch_responder
// PURPOSE
//   Memory-side end of the 4-bit multiplexed CPU instruction bus: tracks the 8-phase bus cycle
//   (A1 A2 A3 M1 M2 X1 X2 X3), captures the PC nibbles the CPU drives in A1/A2 and the chip
//   nibble in A3, fetches one byte from program memory, and returns opcode/operand nibbles in
//   M1/M2. Sits between the CPU bus pins and the program store.
// PARAMETERS
//   CHIP_ID     4'h0   A3 nibble value this responder answers to (used only with chip select)
// PORTS
//   clock       in   1  bus clock, all state on rising edge
//   reset_n     in   1  asynchronous active-low reset
//   sync        in   1  high during the A1 phase of every bus cycle
//   halt        in   1  freezes all state; responder releases the bus
//   bus_in      in   4  nibble currently on the CPU bus
//   bus_out     out  4  nibble driven onto the bus when bus_oe=1, else 4'h0
//   bus_oe      out  1  bus drive enable
//   mem_addr    out  8  registered byte address {A2 nibble, A1 nibble}
//   mem_req     out  1  one-clock read strobe in A3
//   mem_data    in   8  program byte for mem_addr, sampled at end of A3
//   sync_err    out  1  one-clock pulse: sync seen when phase counter != A1
// BEHAVIOUR
//   - Reset: phase=A1(0), addr=0, inst=0, frame_valid=0, selected=0; bus_oe=0, bus_out=0,
//     mem_addr=0, mem_req=0, sync_err=0. Asserting reset mid-cycle aborts the fetch; no drive
//     until a full A1..A3 follows the next sync.
//   - Phase counter (3 bit): sync=1 -> next phase=A2(1), frame_valid<=1; otherwise phase+1,
//     wrapping X3(7)->A1(0). sync while phase!=0 -> sync_err pulses, counter resyncs.
//   - End of A1: addr[3:0]<=bus_in. End of A2: addr[7:4]<=bus_in.
//   - During A3: mem_req=1 (combinational from phase, gated by !halt); at end of A3:
//     inst<=mem_data, selected<=frame_valid & chip_match.
//   - M1: bus_oe=selected, bus_out=inst[7:4]. M2: bus_oe=selected, bus_out=inst[3:0].
//     All other phases: bus_oe=0, bus_out=0. Latency: mem_data->bus = 1 clock (M1).
//   - bus_out=0 whenever bus_oe=0; bus_oe never asserts in A1..A3 (CPU owns bus).
//   - halt=1: all registers hold, bus_oe=0, mem_req=0, sync ignored; resumes same phase.
//   - selected cleared at end of M2 so a stale byte is never redriven.
// CONFIGURATION
//   ROM_CHIP_SELECT_EN defined: chip_match = (A3 bus_in == CHIP_ID); unmatched cycles fetch
//     nothing visible (mem_req still pulses) and keep bus_oe=0.
//   Not defined: chip_match=1, A3 nibble ignored, CHIP_ID unused.
// STRUCTURE
//   - Shared include bus_cycle.vh: phase constants CYC_A1..CYC_X3 (3'h0..3'h7), shared with
//     the CPU-side blocks that use the same phase numbering.
//   - One sub-module: bus_phase_counter (sync/halt/wrap/sync_err logic); rest inline.
// TESTING
//   - Reset 3 clocks, no sync for 16 clocks -> bus_oe stays 0, mem_req pulses only in A3 slots.
//   - sync, bus_in A1=4'h5 A2=4'hA A3=CHIP_ID, mem_data=8'hD3 -> mem_addr=8'hA5 in A3,
//     M1 bus_out=4'hD, M2 bus_out=4'h3, bus_oe=1 exactly 2 clocks.
//   - Back-to-back cycles, addrs 8'hFF then 8'h00 -> correct bytes, no overlap, wrap X3->A1.
//   - sync asserted in X1 -> sync_err one clock, next phase A2, following fetch correct.
//   - halt held 5 clocks during M1 -> bus_oe=0 while halted, on release M1 then M2 drive.
//   - ROM_CHIP_SELECT_EN, A3=CHIP_ID^4'h1 -> bus_oe=0 in M1/M2; reset_n low in A2 -> no drive.

Source files
------------

// File: rtl/rom_fetch_responder_pkg.sv
// Shared bus-cycle definitions for the 4-bit multiplexed instruction bus.
// Phase numbering matches the CPU-side blocks: A1..X3 = 0..7.
package rom_fetch_responder_pkg;

  typedef enum logic [2:0] {
    CYC_A1 = 3'h0,
    CYC_A2 = 3'h1,
    CYC_A3 = 3'h2,
    CYC_M1 = 3'h3,
    CYC_M2 = 3'h4,
    CYC_X1 = 3'h5,
    CYC_X2 = 3'h6,
    CYC_X3 = 3'h7
  } bus_phase_e;

  function automatic logic [3:0] inst_nibble(input logic [7:0] inst, input logic high);
    return high ? inst[7:4] : inst[3:0];
  endfunction

endpackage

// File: rtl/rom_fetch_responder_phase_ctr.sv
// Eight-phase bus cycle tracker: free-runs A1..X3, realigns on sync, freezes on halt.
//   state  | meaning
//   CYC_A1 | CPU drives PC[3:0]
//   CYC_A2 | CPU drives PC[7:4]
//   CYC_A3 | CPU drives chip nibble, program byte fetched
//   CYC_M1 | responder drives opcode nibble
//   CYC_M2 | responder drives operand nibble
//   CYC_X1..CYC_X3 | execute slots, bus not driven by responder
module bus_phase_counter
  import rom_fetch_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sync,
  input  logic       halt,
  output bus_phase_e phase_o,
  output logic       frame_valid_o,
  output logic       sync_err_o
);

  bus_phase_e phase_q, phase_d;
  logic       frame_valid_q, frame_valid_d;
  logic       sync_err_q, sync_err_d;

  always_comb begin
    phase_d       = phase_q;
    frame_valid_d = frame_valid_q;
    sync_err_d    = 1'b0;
    if (!halt) begin
      if (sync) begin
        phase_d       = CYC_A2;
        frame_valid_d = 1'b1;
        sync_err_d    = (phase_q != CYC_A1);
      end else begin
        phase_d = bus_phase_e'(phase_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= CYC_A1;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // A sync clock is always treated as A1, so a misaligned sync still captures PC[3:0].
  assign phase_o       = (sync && !halt) ? CYC_A1 : phase_q;
  assign frame_valid_o = frame_valid_q;
  assign sync_err_o    = sync_err_q;

endmodule

// File: rtl/rom_fetch_responder.sv
// Memory-side responder of the 4-bit multiplexed instruction bus.
// Optional ROM_CHIP_SELECT_EN: answer only when the A3 nibble equals CHIP_ID.
module rom_fetch_responder
  import rom_fetch_responder_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sync,
  input  logic       halt,
  input  logic [3:0] bus_in,
  output logic [3:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] mem_addr,
  output logic       mem_req,
  input  logic [7:0] mem_data,
  output logic       sync_err
);

`ifdef ROM_CHIP_SELECT_EN
  localparam bit CHIP_SEL_EN = 1'b1;
`else
  localparam bit CHIP_SEL_EN = 1'b0;
`endif

  bus_phase_e phase;
  logic       frame_valid;
  logic       chip_match;
  logic [7:0] addr_q;
  logic [7:0] inst_q;
  logic       selected_q;
  logic       drive_slot;

  bus_phase_counter u_phase (
    .clock        (clock),
    .reset_n      (reset_n),
    .sync         (sync),
    .halt         (halt),
    .phase_o      (phase),
    .frame_valid_o(frame_valid),
    .sync_err_o   (sync_err)
  );

  assign chip_match = !CHIP_SEL_EN || (bus_in == CHIP_ID);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= 8'h00;
      inst_q     <= 8'h00;
      selected_q <= 1'b0;
    end else if (!halt) begin
      case (phase)
        CYC_A1: addr_q[3:0] <= bus_in;
        CYC_A2: addr_q[7:4] <= bus_in;
        CYC_A3: begin
          inst_q     <= mem_data;
          selected_q <= frame_valid && chip_match;
        end
        // Drop selection once the operand is out so a stale byte is never redriven.
        CYC_M2: selected_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign drive_slot = (phase == CYC_M1) || (phase == CYC_M2);
  assign bus_oe     = !halt && selected_q && drive_slot;
  assign bus_out    = bus_oe ? inst_nibble(inst_q, phase == CYC_M1) : 4'h0;
  assign mem_req    = !halt && (phase == CYC_A3);
  assign mem_addr   = addr_q;

endmodule
